// File: rtl/line_rasterizer_if.sv
// ---------------------------------------------------------------------------
// line_rasterizer_if
//   Bundles the line request inputs and the pixel output channel of the
//   Bresenham line rasterizer.
//
//   Handshake semantics (single place they are written down):
//     * Request side: start is a one-cycle request. It is accepted only while
//       busy=0 and is dropped (never queued) while busy=1. x_start/y_start/
//       x_end/y_end/color_in are sampled in the same cycle as an accepted start.
//     * Pixel side: write is the valid. hold is the inverse of ready: a pixel
//       (x,y,color) transfers on every cycle with write=1, and write is never
//       asserted while hold=1. A held pixel stays on x/y until it transfers.
//     * done pulses for one cycle after the last pixel has transferred.
//
//   Signals
//     start, x_start[7:0], y_start[6:0], x_end[7:0], y_end[6:0],
//     color_in[CW-1:0], hold                     : master -> slave
//     x[7:0], y[6:0], color[CW-1:0], write,
//     busy, done                                 : slave -> master
//
//   Modports
//     master : the requester / pixel consumer side
//     slave  : the rasterizer side
// ---------------------------------------------------------------------------
interface line_rasterizer_if #(
  parameter int COLOR_CHANNEL_DEPTH = 2
);
  localparam int CW = 3 * COLOR_CHANNEL_DEPTH;

  // request
  logic          start;
  logic [7:0]    x_start;
  logic [6:0]    y_start;
  logic [7:0]    x_end;
  logic [6:0]    y_end;
  logic [CW-1:0] color_in;

  // pixel channel
  logic          hold;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [CW-1:0] color;
  logic          write;

  // status
  logic          busy;
  logic          done;

  modport master (
    output start, x_start, y_start, x_end, y_end, color_in, hold,
    input  x, y, color, write, busy, done
  );

  modport slave (
    input  start, x_start, y_start, x_end, y_end, color_in, hold,
    output x, y, color, write, busy, done
  );
endinterface

// File: rtl/line_rasterizer.sv
// ---------------------------------------------------------------------------
// line_rasterizer
//   Bresenham line generator. Accepts two endpoints and a colour and emits
//   one pixel per clock towards one input channel of the point mux that
//   feeds the VGA adapter. hold pauses emission while the other mux channel
//   owns the framebuffer.
//
//   Parameters
//     COLOR_CHANNEL_DEPTH : bits per RGB channel, colour width CW = 3*depth
//
//   Ports
//     clock      : system clock, all state on the rising edge
//     reset      : synchronous, active-high; aborts any line in progress
//     bus        : line_rasterizer_if.slave (request, pixel channel, status)
//     dbg_state  : current FSM state (0 IDLE, 1 SETUP, 2 DRAW, 3 DONE)
//
//   Build option
//     LINE_RASTERIZER_CLIP_EN : when defined, write is additionally gated by
//       (x < 160 && y < 120). Off-screen pixels still consume one DRAW cycle
//       each, so the done pulse lands on the same cycle either way.
//
//   Timing
//     start accepted in cycle N -> SETUP in N+1 -> first pixel in N+2.
//     Pixel count = max(|dx|,|dy|)+1; the final pixel is exactly (x_end,y_end).
// ---------------------------------------------------------------------------
module line_rasterizer #(
  parameter int COLOR_CHANNEL_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  line_rasterizer_if.slave   bus,
  output logic [1:0]         dbg_state
);

  localparam int CW = 3 * COLOR_CHANNEL_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [CW-1:0]     color_q;
  logic [7:0]        x_end_q;
  logic [6:0]        y_end_q;
  logic signed [8:0] dx_q;      // |x_end - x_start|, always >= 0
  logic signed [7:0] dy_q;      // -|y_end - y_start|, always <= 0
  logic              sx_neg_q;  // x steps by -1 instead of +1
  logic              sy_neg_q;  // y steps by -1 instead of +1
  logic signed [9:0] err_q;

  // -------------------------------------------------------------------------
  // SETUP arithmetic. x_q/y_q still hold the start point in SETUP, so the
  // deltas are formed against them rather than against separate copies.
  // -------------------------------------------------------------------------
  logic signed [8:0] dx_diff;
  logic signed [8:0] dx_abs;
  logic signed [7:0] dy_diff;
  logic signed [7:0] dy_neg;
  logic signed [9:0] err_init;

  always_comb begin
    dx_diff  = $signed({1'b0, x_end_q}) - $signed({1'b0, x_q});
    dx_abs   = dx_diff[8] ? -dx_diff : dx_diff;
    dy_diff  = $signed({1'b0, y_end_q}) - $signed({1'b0, y_q});
    dy_neg   = dy_diff[7] ? dy_diff : -dy_diff;
    err_init = $signed({dx_abs[8], dx_abs}) + $signed({{2{dy_neg[7]}}, dy_neg});
  end

  // -------------------------------------------------------------------------
  // DRAW step. Both axis decisions look at the pre-update error; when both
  // fire in one cycle the line takes a diagonal step and both deltas are
  // folded into the error together.
  // -------------------------------------------------------------------------
  logic signed [10:0] e2;
  logic signed [10:0] dx_ext11;
  logic signed [10:0] dy_ext11;
  logic signed [9:0]  dx_ext10;
  logic signed [9:0]  dy_ext10;
  logic               step_x;
  logic               step_y;
  logic signed [9:0]  err_next;
  logic [7:0]         x_next;
  logic [6:0]         y_next;
  logic               at_end;

  always_comb begin
    e2       = $signed({err_q, 1'b0});
    dx_ext11 = $signed({{2{dx_q[8]}}, dx_q});
    dy_ext11 = $signed({{3{dy_q[7]}}, dy_q});
    dx_ext10 = $signed({dx_q[8], dx_q});
    dy_ext10 = $signed({{2{dy_q[7]}}, dy_q});
    step_x   = (e2 >= dy_ext11);
    step_y   = (e2 <= dx_ext11);
    err_next = err_q
             + (step_x ? dy_ext10 : 10'sd0)
             + (step_y ? dx_ext10 : 10'sd0);
    x_next   = step_x ? (sx_neg_q ? x_q - 8'd1 : x_q + 8'd1) : x_q;
    y_next   = step_y ? (sy_neg_q ? y_q - 7'd1 : y_q + 7'd1) : y_q;
    at_end   = (x_q == x_end_q) && (y_q == y_end_q);
  end

  // -------------------------------------------------------------------------
  // Visibility of the current pixel on the 160x120 framebuffer.
  // -------------------------------------------------------------------------
  logic on_screen;

`ifdef LINE_RASTERIZER_CLIP_EN
  assign on_screen = (x_q < 8'd160) && (y_q < 7'd120);
`else
  assign on_screen = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and status outputs
  // -------------------------------------------------------------------------
  logic write_c;
  logic busy_c;
  logic done_c;

  always_comb begin
    state_d = state_q;
    write_c = 1'b0;
    busy_c  = 1'b1;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_DRAW;
      end
      S_DRAW: begin
        write_c = ~bus.hold & on_screen;
        // The end test is made on the pixel being emitted, so the endpoint
        // itself is always written before leaving DRAW.
        if (!bus.hold && at_end) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath update
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      color_q  <= '0;
      x_end_q  <= 8'd0;
      y_end_q  <= 7'd0;
      dx_q     <= 9'sd0;
      dy_q     <= 8'sd0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= 10'sd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x_q     <= bus.x_start;
            y_q     <= bus.y_start;
            x_end_q <= bus.x_end;
            y_end_q <= bus.y_end;
            color_q <= bus.color_in;
          end
        end
        S_SETUP: begin
          dx_q     <= dx_abs;
          dy_q     <= dy_neg;
          sx_neg_q <= (x_end_q < x_q);
          sy_neg_q <= (y_end_q < y_q);
          err_q    <= err_init;
        end
        S_DRAW: begin
          // Held cycles freeze position and error so no pixel is lost or
          // repeated; the endpoint cycle leaves x/y on the last pixel.
          if (!bus.hold && !at_end) begin
            x_q   <= x_next;
            y_q   <= y_next;
            err_q <= err_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.color = color_q;
  assign bus.write = write_c;
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// ---------------------------------------------------------------------------
// tb_line_rasterizer
//   Table vectors with hand-derived pixel lists, hand-written hold/reset
//   sequences, and random lines checked against a Bresenham reference model
//   evaluated with integer arithmetic.
// ---------------------------------------------------------------------------
module tb_line_rasterizer;

  localparam int CCD = 2;
  localparam int CW  = 3 * CCD;

`ifdef LINE_RASTERIZER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  line_rasterizer_if #(.COLOR_CHANNEL_DEPTH(CCD)) bus ();

  line_rasterizer #(.COLOR_CHANNEL_DEPTH(CCD)) dut (
    .clock     (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [14:0] exp_q[$];   // {x,y} of pixels expected to be written, in order
  logic [14:0] full_q[$];  // {x,y} of every pixel the line visits, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit on_screen(input logic [14:0] p);
    return !CLIP_EN || ((p[14:7] < 8'd160) && (p[6:0] < 7'd120));
  endfunction

  // Reference Bresenham walk over plain integers.
  task automatic model_line(input int xs, input int ys, input int xe, input int ye);
    int dx, dy, sx, sy, err, e2, cx, cy;
    full_q.delete();
    dx  = (xe > xs) ? xe - xs : xs - xe;
    dy  = -((ye > ys) ? ye - ys : ys - ye);
    sx  = (xe >= xs) ? 1 : -1;
    sy  = (ye >= ys) ? 1 : -1;
    err = dx + dy;
    cx  = xs;
    cy  = ys;
    for (int k = 0; k < 1000; k++) begin
      full_q.push_back({8'(cx), 7'(cy)});
      if (cx == xe && cy == ye) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver: issue one line and check it cycle by cycle against full_q.
  //   hold_after/hold_len : hold for hold_len cycles once hold_after pixels
  //                         have transferred
  //   rand_hold           : random hold on about a quarter of DRAW cycles
  //   poke                : pulse start with other endpoints while busy
  // -------------------------------------------------------------------------
  task automatic run_line(input logic [7:0] xs, input logic [6:0] ys,
                          input logic [7:0] xe, input logic [6:0] ye,
                          input logic [CW-1:0] col, input int hold_after,
                          input int hold_len, input bit rand_hold, input bit poke);
    int   npix;
    int   idx;
    int   held;
    bit   finished;
    logic h;
    logic [14:0] got;
    logic [14:0] want;

    exp_q.delete();
    foreach (full_q[i]) if (on_screen(full_q[i])) exp_q.push_back(full_q[i]);
    npix = full_q.size();

    // Request cycle; hold is raised too, which must not block acceptance.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.x_start  = xs;
    bus.y_start  = ys;
    bus.x_end    = xe;
    bus.y_end    = ye;
    bus.color_in = col;
    bus.hold     = 1'b1;

    // SETUP cycle
    @(negedge clk);
    bus.start = poke;
    if (poke) begin
      bus.x_start  = xs ^ 8'h55;
      bus.y_start  = ys ^ 7'h2a;
      bus.x_end    = xe ^ 8'h0f;
      bus.y_end    = ye ^ 7'h11;
      bus.color_in = ~col;
    end
    #1;
    check("setup_busy", 32'(bus.busy), 32'd1);
    check("setup_write", 32'(bus.write), 32'd0);

    idx = 0;
    held = 0;
    finished = 1'b0;
    for (int cyc = 1; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      h = 1'b0;
      if (idx < npix) begin
        if (rand_hold) begin
          h = ($urandom_range(0, 3) == 0);
        end else if (idx == hold_after && held < hold_len) begin
          h = 1'b1;
          held++;
        end
      end
      bus.hold = h;
      #1;
      if (idx < npix) begin
        check("draw_write", 32'(bus.write), 32'(!h && on_screen(full_q[idx])));
        check("draw_done", 32'(bus.done), 32'd0);
        check("draw_busy", 32'(bus.busy), 32'd1);
        if (bus.write) begin
          got = {bus.x, bus.y};
          if (exp_q.size() == 0) begin
            check("extra_pixel", 32'(got), 32'h7fff);
          end else begin
            want = exp_q.pop_front();
            check("pixel_xy", 32'(got), 32'(want));
            check("pixel_color", 32'(bus.color), 32'(col));
          end
        end
        if (h) check("frozen_xy", 32'({bus.x, bus.y}), 32'(full_q[idx]));
        if (!h) idx++;
      end else begin
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_write", 32'(bus.write), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd1);
        finished = 1'b1;
      end
    end
    if (!finished) check("line_timeout", 32'd0, 32'd1);

    bus.hold = 1'b0;
    @(negedge clk);
    #1;
    check("after_busy", 32'(bus.busy), 32'd0);
    check("after_done", 32'(bus.done), 32'd0);
    check("after_write", 32'(bus.write), 32'd0);
    check("leftover_pixels", 32'(exp_q.size()), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0]      xs;
    logic [6:0]      ys;
    logic [7:0]      xe;
    logic [6:0]      ye;
    logic [CW-1:0]   col;
    int              npix;
    logic [0:3][7:0] px;
    logic [0:3][6:0] py;
    int              hold_after;
    int              hold_len;
    bit              poke;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{xs: 8'd0, ys: 7'd0, xe: 8'd3, ye: 7'd0, col: 6'h30, npix: 4,
                px: '{8'd0, 8'd1, 8'd2, 8'd3}, py: '{7'd0, 7'd0, 7'd0, 7'd0},
                hold_after: -1, hold_len: 0, poke: 1'b0};
    vecs[1] = '{xs: 8'd5, ys: 7'd5, xe: 8'd5, ye: 7'd5, col: 6'h0c, npix: 1,
                px: '{8'd5, 8'd0, 8'd0, 8'd0}, py: '{7'd5, 7'd0, 7'd0, 7'd0},
                hold_after: -1, hold_len: 0, poke: 1'b1};
    vecs[2] = '{xs: 8'd10, ys: 7'd10, xe: 8'd7, ye: 7'd7, col: 6'h3f, npix: 4,
                px: '{8'd10, 8'd9, 8'd8, 8'd7}, py: '{7'd10, 7'd9, 7'd8, 7'd7},
                hold_after: -1, hold_len: 0, poke: 1'b0};
    vecs[3] = '{xs: 8'd0, ys: 7'd0, xe: 8'd1, ye: 7'd3, col: 6'h21, npix: 4,
                px: '{8'd0, 8'd0, 8'd1, 8'd1}, py: '{7'd0, 7'd1, 7'd2, 7'd3},
                hold_after: -1, hold_len: 0, poke: 1'b0};
    vecs[4] = '{xs: 8'd0, ys: 7'd0, xe: 8'd3, ye: 7'd0, col: 6'h30, npix: 4,
                px: '{8'd0, 8'd1, 8'd2, 8'd3}, py: '{7'd0, 7'd0, 7'd0, 7'd0},
                hold_after: 2, hold_len: 3, poke: 1'b0};
    vecs[5] = '{xs: 8'd158, ys: 7'd0, xe: 8'd161, ye: 7'd0, col: 6'h07, npix: 4,
                px: '{8'd158, 8'd159, 8'd160, 8'd161}, py: '{7'd0, 7'd0, 7'd0, 7'd0},
                hold_after: -1, hold_len: 0, poke: 1'b0};

    // Reset state
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.x_start  = 8'd0;
    bus.y_start  = 7'd0;
    bus.x_end    = 8'd0;
    bus.y_end    = 7'd0;
    bus.color_in = '0;
    bus.hold     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_color", 32'(bus.color), 32'd0);
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      full_q.delete();
      for (int k = 0; k < vecs[v].npix; k++) full_q.push_back({vecs[v].px[k], vecs[v].py[k]});
      run_line(vecs[v].xs, vecs[v].ys, vecs[v].xe, vecs[v].ye, vecs[v].col,
               vecs[v].hold_after, vecs[v].hold_len, 1'b0, vecs[v].poke);
    end

    // Reset in the middle of a long line
    begin
      int writes;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.x_start  = 8'd0;
      bus.y_start  = 7'd0;
      bus.x_end    = 8'd200;
      bus.y_end    = 7'd0;
      bus.color_in = 6'h15;
      writes = 0;
      for (int cyc = 0; cyc < 400 && writes < 50; cyc++) begin
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        if (bus.write) writes++;
      end
      check("mid_reset_reached_50", 32'(writes), 32'd50);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("mid_rst_x", 32'(bus.x), 32'd0);
      check("mid_rst_y", 32'(bus.y), 32'd0);
      check("mid_rst_color", 32'(bus.color), 32'd0);
      check("mid_rst_write", 32'(bus.write), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_done", 32'(bus.done), 32'd0);
      reset = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
        @(negedge clk);
        #1;
        check("post_rst_write", 32'(bus.write), 32'd0);
        check("post_rst_done", 32'(bus.done), 32'd0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
      end
      full_q.delete();
      for (int k = 0; k < vecs[0].npix; k++) full_q.push_back({vecs[0].px[k], vecs[0].py[k]});
      run_line(vecs[0].xs, vecs[0].ys, vecs[0].xe, vecs[0].ye, vecs[0].col, -1, 0, 1'b0, 1'b0);
    end

    // Random lines with random hold against the reference model
    for (int r = 0; r < 24; r++) begin
      logic [7:0]    rxs, rxe;
      logic [6:0]    rys, rye;
      logic [CW-1:0] rcol;
      rxs  = 8'($urandom_range(0, 255));
      rys  = 7'($urandom_range(0, 127));
      if (r % 6 == 0) begin
        rxe = rxs;
        rye = rys;
      end else begin
        rxe = 8'($urandom_range(0, 255));
        rye = 7'($urandom_range(0, 127));
      end
      rcol = CW'($urandom_range(0, (1 << CW) - 1));
      model_line(int'(rxs), int'(rys), int'(rxe), int'(rye));
      run_line(rxs, rys, rxe, rye, rcol, -1, 0, 1'b1, (r % 4) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
